// File: rtl/buffer_read_tracker.sv
// Per-PU queued read-request tracker: counts buffer read strobes against each PU's head request.
// Optional sticky error flag built only when BRT_ERR_CHECK_EN is defined.
module buffer_read_tracker #(
  parameter int NUM_PU      = 4,
  parameter int D_TYPE_W    = 2,
  parameter int RD_SIZE_W   = 20,
  parameter int PU_ID_W     = $clog2(NUM_PU) + 1,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_req,
  input  logic [RD_SIZE_W-1:0]       rd_req_size,
  input  logic [PU_ID_W-1:0]         rd_req_pu_id,
  input  logic [D_TYPE_W-1:0]        rd_req_d_type,
  output logic                       rd_req_ready,
  input  logic [NUM_PU-1:0]          buffer_read_req,
  output logic [NUM_PU-1:0]          buffer_read_last,
  output logic [NUM_PU-1:0]          buffer_read_empty,
  output logic [NUM_PU*D_TYPE_W-1:0] buffer_read_d_type,
  output logic                       read_error
);

  localparam int AW = $clog2(QUEUE_DEPTH);

  logic              accept;
  logic [NUM_PU-1:0] full;

  assign accept = rd_req && rd_req_ready;

  // Ready drops only when the addressed PU queue is full (no pop bypass).
  always_comb begin
    rd_req_ready = 1'b1;
    for (int i = 0; i < NUM_PU; i++) begin
      if (full[i] && (rd_req_pu_id == PU_ID_W'(i)))
        rd_req_ready = 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_PU; g++) begin : g_pu
    logic [AW:0]            wp;
    logic [AW:0]            rp;
    logic [AW:0]            wp_nx;
    logic [AW:0]            rp_nx;
    logic [RD_SIZE_W-1:0]   cnt;
    logic                   emp;
    logic                   enq;
    logic                   cnt_rd;
    logic                   pop;
    logic [RD_SIZE_W-1:0]   head_sz;
    logic [RD_SIZE_W-1:0]   sz_mem [QUEUE_DEPTH];
    logic [D_TYPE_W-1:0]    dt_mem [QUEUE_DEPTH];

    assign full[g]  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign enq      = accept && (rd_req_size != '0)
                      && (rd_req_pu_id == PU_ID_W'(g));
    assign head_sz  = sz_mem[rp[AW-1:0]];
    assign cnt_rd   = buffer_read_req[g] && !emp;
    assign pop      = cnt_rd && (cnt == head_sz - RD_SIZE_W'(1));
    assign wp_nx    = enq ? wp + (AW+1)'(1) : wp;
    assign rp_nx    = pop ? rp + (AW+1)'(1) : rp;

    assign buffer_read_last[g]  = pop;
    assign buffer_read_empty[g] = emp;
    assign buffer_read_d_type[g*D_TYPE_W +: D_TYPE_W] =
      emp ? '0 : dt_mem[rp[AW-1:0]];

    // Pointers, read counter and registered empty flag.
    always_ff @(posedge clk) begin
      if (reset) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        emp <= 1'b1;
      end else begin
        wp  <= wp_nx;
        rp  <= rp_nx;
        emp <= (wp_nx == rp_nx);
        if (pop)
          cnt <= '0;
        else if (cnt_rd)
          cnt <= cnt + RD_SIZE_W'(1);
      end
    end

    // Request storage; contents only observed while the queue is non-empty.
    always_ff @(posedge clk) begin
      if (enq) begin
        sz_mem[wp[AW-1:0]] <= rd_req_size;
        dt_mem[wp[AW-1:0]] <= rd_req_d_type;
      end
    end
  end

`ifdef BRT_ERR_CHECK_EN
  logic pu_ok;
  logic err;

  assign pu_ok      = rd_req_pu_id < PU_ID_W'(NUM_PU);
  assign read_error = err;

  // Sticky: strobe on an empty queue or request to a nonexistent PU.
  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if ((|(buffer_read_req & buffer_read_empty)) || (accept && !pu_ok))
      err <= 1'b1;
  end
`else
  assign read_error = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_read_tracker.sv
// Self-checking bench for buffer_read_tracker.
// Expected last/d_type values are queued at stimulus time and popped when sampled.
module tb_buffer_read_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [19:0] rd_req_size = '0;
  logic [2:0]  rd_req_pu_id = '0;
  logic [1:0]  rd_req_d_type = '0;
  logic        rd_req_ready;
  logic [3:0]  buffer_read_req = '0;
  logic [3:0]  buffer_read_last;
  logic [3:0]  buffer_read_empty;
  logic [7:0]  buffer_read_d_type;
  logic        read_error;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_last_q[$];
  logic [1:0] exp_dt_q[$];
  logic [3:0] e;
  logic [1:0] ed;
  logic       exp_err;

  buffer_read_tracker dut (
    .clk                (clk),
    .reset              (reset),
    .rd_req             (rd_req),
    .rd_req_size        (rd_req_size),
    .rd_req_pu_id       (rd_req_pu_id),
    .rd_req_d_type      (rd_req_d_type),
    .rd_req_ready       (rd_req_ready),
    .buffer_read_req    (buffer_read_req),
    .buffer_read_last   (buffer_read_last),
    .buffer_read_empty  (buffer_read_empty),
    .buffer_read_d_type (buffer_read_d_type),
    .read_error         (read_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [2:0] pu, input logic [19:0] sz,
                     input logic [1:0] dt);
    rd_req        = 1'b1;
    rd_req_pu_id  = pu;
    rd_req_size   = sz;
    rd_req_d_type = dt;
    tick();
    rd_req        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (buffer_read_empty !== 4'hF) begin
      errors++;
      $display("FAIL reset_empty got %b exp 1111", buffer_read_empty);
    end
    checks++;
    if (buffer_read_last !== 4'h0) begin
      errors++;
      $display("FAIL reset_last got %b exp 0000", buffer_read_last);
    end
    checks++;
    if (buffer_read_d_type !== 8'h00) begin
      errors++;
      $display("FAIL reset_dtype got %h exp 00", buffer_read_d_type);
    end
    checks++;
    if (read_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b exp 0", read_error);
    end
    checks++;
    if (rd_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", rd_req_ready);
    end
  endtask

  task automatic test_basic();
    enq(3'd0, 20'd3, 2'd2);
    #1;
    checks++;
    if (buffer_read_empty !== 4'b1110) begin
      errors++;
      $display("FAIL basic_empty got %b exp 1110", buffer_read_empty);
    end
    checks++;
    if (buffer_read_d_type[1:0] !== 2'd2) begin
      errors++;
      $display("FAIL basic_dtype got %0d exp 2", buffer_read_d_type[1:0]);
    end
    exp_last_q.push_back(4'b0000);
    exp_last_q.push_back(4'b0000);
    exp_last_q.push_back(4'b0001);
    for (int k = 0; k < 3; k++) begin
      buffer_read_req = 4'b0001;
      #1;
      e = exp_last_q.pop_front();
      checks++;
      if (buffer_read_last !== e) begin
        errors++;
        $display("FAIL basic_last%0d got %b exp %b", k, buffer_read_last, e);
      end
      tick();
    end
    buffer_read_req = '0;
    #1;
    checks++;
    if (buffer_read_empty !== 4'hF) begin
      errors++;
      $display("FAIL basic_drained got %b exp 1111", buffer_read_empty);
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) enq(3'd1, 20'd1, 2'd1);
    rd_req_pu_id = 3'd1;
    #1;
    checks++;
    if (rd_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_pu1 got %b exp 0", rd_req_ready);
    end
    rd_req_pu_id = 3'd2;
    #1;
    checks++;
    if (rd_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_pu2 got %b exp 1", rd_req_ready);
    end
    rd_req_pu_id    = 3'd1;
    buffer_read_req = 4'b0010;
    #1;
    checks++;
    if (buffer_read_last !== 4'b0010) begin
      errors++;
      $display("FAIL full_pop_last got %b exp 0010", buffer_read_last);
    end
    checks++;
    if (rd_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_nobypass got %b exp 0", rd_req_ready);
    end
    tick();
    buffer_read_req = '0;
    #1;
    checks++;
    if (rd_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_restored got %b exp 1", rd_req_ready);
    end
    for (int k = 0; k < 3; k++) exp_last_q.push_back(4'b0010);
    for (int k = 0; k < 3; k++) begin
      buffer_read_req = 4'b0010;
      #1;
      e = exp_last_q.pop_front();
      checks++;
      if (buffer_read_last !== e) begin
        errors++;
        $display("FAIL full_drain%0d got %b exp %b", k, buffer_read_last, e);
      end
      tick();
    end
    buffer_read_req = '0;
    #1;
    checks++;
    if (buffer_read_empty !== 4'hF) begin
      errors++;
      $display("FAIL full_empty got %b exp 1111", buffer_read_empty);
    end
  endtask

  task automatic test_back_to_back();
    enq(3'd0, 20'd2, 2'd1);
    enq(3'd0, 20'd1, 2'd3);
    exp_last_q.push_back(4'b0000);
    exp_dt_q.push_back(2'd1);
    exp_last_q.push_back(4'b0001);
    exp_dt_q.push_back(2'd1);
    exp_last_q.push_back(4'b0001);
    exp_dt_q.push_back(2'd3);
    for (int k = 0; k < 3; k++) begin
      buffer_read_req = 4'b0001;
      #1;
      e  = exp_last_q.pop_front();
      ed = exp_dt_q.pop_front();
      checks++;
      if (buffer_read_last !== e) begin
        errors++;
        $display("FAIL b2b_last%0d got %b exp %b", k, buffer_read_last, e);
      end
      checks++;
      if (buffer_read_d_type[1:0] !== ed) begin
        errors++;
        $display("FAIL b2b_dtype%0d got %0d exp %0d", k,
                 buffer_read_d_type[1:0], ed);
      end
      tick();
    end
    buffer_read_req = '0;
    #1;
    checks++;
    if (buffer_read_empty !== 4'hF) begin
      errors++;
      $display("FAIL b2b_empty got %b exp 1111", buffer_read_empty);
    end
  endtask

  task automatic test_multi_pop();
    enq(3'd0, 20'd1, 2'd0);
    enq(3'd3, 20'd1, 2'd2);
    rd_req          = 1'b1;
    rd_req_pu_id    = 3'd3;
    rd_req_size     = 20'd5;
    rd_req_d_type   = 2'd1;
    buffer_read_req = 4'b1001;
    #1;
    checks++;
    if (buffer_read_last !== 4'b1001) begin
      errors++;
      $display("FAIL mpop_last got %b exp 1001", buffer_read_last);
    end
    checks++;
    if (rd_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mpop_ready got %b exp 1", rd_req_ready);
    end
    tick();
    rd_req          = 1'b0;
    buffer_read_req = '0;
    #1;
    checks++;
    if (buffer_read_empty !== 4'b0111) begin
      errors++;
      $display("FAIL mpop_empty got %b exp 0111", buffer_read_empty);
    end
    checks++;
    if (buffer_read_d_type[7:6] !== 2'd1) begin
      errors++;
      $display("FAIL mpop_dtype got %0d exp 1", buffer_read_d_type[7:6]);
    end
    for (int k = 0; k < 4; k++) exp_last_q.push_back(4'b0000);
    exp_last_q.push_back(4'b1000);
    for (int k = 0; k < 5; k++) begin
      buffer_read_req = 4'b1000;
      #1;
      e = exp_last_q.pop_front();
      checks++;
      if (buffer_read_last !== e) begin
        errors++;
        $display("FAIL mpop_last%0d got %b exp %b", k, buffer_read_last, e);
      end
      tick();
    end
    buffer_read_req = '0;
    #1;
    checks++;
    if (buffer_read_empty !== 4'hF) begin
      errors++;
      $display("FAIL mpop_drained got %b exp 1111", buffer_read_empty);
    end
  endtask

  task automatic test_errors();
`ifdef BRT_ERR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    buffer_read_req = 4'b0100;
    rd_req          = 1'b1;
    rd_req_pu_id    = 3'd4;
    rd_req_size     = 20'd3;
    rd_req_d_type   = 2'd1;
    #1;
    checks++;
    if (buffer_read_last !== 4'b0000) begin
      errors++;
      $display("FAIL err_last got %b exp 0000", buffer_read_last);
    end
    checks++;
    if (rd_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_ready got %b exp 1", rd_req_ready);
    end
    tick();
    rd_req          = 1'b0;
    buffer_read_req = '0;
    #1;
    checks++;
    if (buffer_read_empty !== 4'hF) begin
      errors++;
      $display("FAIL err_empty got %b exp 1111", buffer_read_empty);
    end
    checks++;
    if (read_error !== exp_err) begin
      errors++;
      $display("FAIL err_flag got %b exp %b", read_error, exp_err);
    end
    rd_req       = 1'b1;
    rd_req_pu_id = 3'd2;
    rd_req_size  = 20'd0;
    #1;
    checks++;
    if (rd_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready got %b exp 1", rd_req_ready);
    end
    tick();
    rd_req = 1'b0;
    #1;
    checks++;
    if (buffer_read_empty !== 4'hF) begin
      errors++;
      $display("FAIL zero_empty got %b exp 1111", buffer_read_empty);
    end
    enq(3'd2, 20'd2, 2'd2);
    exp_last_q.push_back(4'b0000);
    exp_last_q.push_back(4'b0100);
    for (int k = 0; k < 2; k++) begin
      buffer_read_req = 4'b0100;
      #1;
      e = exp_last_q.pop_front();
      checks++;
      if (buffer_read_last !== e) begin
        errors++;
        $display("FAIL err_cnt%0d got %b exp %b", k, buffer_read_last, e);
      end
      tick();
    end
    buffer_read_req = '0;
  endtask

  task automatic test_reset_mid();
    enq(3'd0, 20'd5, 2'd3);
    exp_last_q.push_back(4'b0000);
    exp_last_q.push_back(4'b0000);
    for (int k = 0; k < 2; k++) begin
      buffer_read_req = 4'b0001;
      #1;
      e = exp_last_q.pop_front();
      checks++;
      if (buffer_read_last !== e) begin
        errors++;
        $display("FAIL rmid_pre%0d got %b exp %b", k, buffer_read_last, e);
      end
      tick();
    end
    buffer_read_req = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (buffer_read_empty !== 4'hF) begin
      errors++;
      $display("FAIL rmid_empty got %b exp 1111", buffer_read_empty);
    end
    checks++;
    if (buffer_read_d_type !== 8'h00) begin
      errors++;
      $display("FAIL rmid_dtype got %h exp 00", buffer_read_d_type);
    end
    checks++;
    if (read_error !== 1'b0) begin
      errors++;
      $display("FAIL rmid_err got %b exp 0", read_error);
    end
    enq(3'd0, 20'd2, 2'd0);
    exp_last_q.push_back(4'b0000);
    exp_last_q.push_back(4'b0001);
    for (int k = 0; k < 2; k++) begin
      buffer_read_req = 4'b0001;
      #1;
      e = exp_last_q.pop_front();
      checks++;
      if (buffer_read_last !== e) begin
        errors++;
        $display("FAIL rmid_post%0d got %b exp %b", k, buffer_read_last, e);
      end
      tick();
    end
    buffer_read_req = '0;
    #1;
    checks++;
    if (buffer_read_empty !== 4'hF) begin
      errors++;
      $display("FAIL rmid_drained got %b exp 1111", buffer_read_empty);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_multi_pop();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
